ray_scheduler: RTL and testbench

RAY_SCHEDULER -- requirements
Module: ray_scheduler

---
 rtl/ray_scheduler.sv | 274 +++++++++++++++++++++++++++
 tb/tb_ray_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_scheduler.sv
// ---------------------------------------------------------------------------
// ray_scheduler
//
// Hands out framebuffer pixels to a pool of ray_unit cores and funnels their
// results back into a single framebuffer write port.
//
// A frame is a raster walk over DISPLAY_WIDTH x DISPLAY_HEIGHT pixels. While
// running, the lowest-index FREE core receives the next pixel. Cores that
// report a finished result compete for the single write port through a
// round-robin arbiter. The frame ends once the last pixel has been handed
// out, every core is idle again and the last write has left the block.
//
// Ports
//   clk_in           sole clock
//   rst_in           asynchronous, active-high reset
//   start_in         frame start request, sampled only in IDLE
//   fractal_sel_in   fractal select, latched at frame start
//   core_valid_out   one-hot, one-cycle dispatch strobe per core
//   pix_hcount_out   shared dispatch hcount (zero when not dispatching)
//   pix_vcount_out   shared dispatch vcount (zero when not dispatching)
//   fractal_sel_out  latched select, broadcast to every core
//   core_ready_in    per-core result-ready flags
//   core_hcount_in   packed per-core returned hcount, core i at [i*H_BITS +: H_BITS]
//   core_vcount_in   packed per-core returned vcount, same packing
//   core_color_in    packed per-core 4-bit shade, same packing
//   fb_we_out        framebuffer write strobe (registered)
//   fb_addr_out      framebuffer write address
//   fb_data_out      framebuffer write data (4-bit shade)
//   busy_out         high whenever the scheduler is not IDLE
//   frame_done_out   one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
module ray_scheduler #(
    parameter int NUM_CORES      = 4,
    parameter int DISPLAY_WIDTH  = 400,
    parameter int DISPLAY_HEIGHT = 300,
    parameter int H_BITS         = 9,
    parameter int V_BITS         = 9,
    parameter int ADDR_BITS      = 17
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        start_in,
    input  logic [2:0]                  fractal_sel_in,
    output logic [NUM_CORES-1:0]        core_valid_out,
    output logic [H_BITS-1:0]           pix_hcount_out,
    output logic [V_BITS-1:0]           pix_vcount_out,
    output logic [2:0]                  fractal_sel_out,
    input  logic [NUM_CORES-1:0]        core_ready_in,
    input  logic [NUM_CORES*H_BITS-1:0] core_hcount_in,
    input  logic [NUM_CORES*V_BITS-1:0] core_vcount_in,
    input  logic [NUM_CORES*4-1:0]      core_color_in,
    output logic                        fb_we_out,
    output logic [ADDR_BITS-1:0]        fb_addr_out,
    output logic [3:0]                  fb_data_out,
    output logic                        busy_out,
    output logic                        frame_done_out
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int PTR_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    // Top-level frame FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Per-core tracking encoding
    localparam logic [1:0] CORE_FREE  = 2'd0;
    localparam logic [1:0] CORE_ARMED = 2'd1;
    localparam logic [1:0] CORE_BUSY  = 2'd2;

    localparam logic [H_BITS-1:0]    H_LAST   = H_BITS'(DISPLAY_WIDTH - 1);
    localparam logic [V_BITS-1:0]    V_LAST   = V_BITS'(DISPLAY_HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] LINE_LEN = ADDR_BITS'(DISPLAY_WIDTH);
    localparam logic [PTR_BITS-1:0]  PTR_LAST = PTR_BITS'(NUM_CORES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]                  state_reg;
    logic [1:0]                  state_next;
    logic [NUM_CORES-1:0][1:0]   core_state_reg;
    logic [NUM_CORES-1:0][1:0]   core_state_next;
    logic [H_BITS-1:0]           h_reg;
    logic [H_BITS-1:0]           h_next;
    logic [V_BITS-1:0]           v_reg;
    logic [V_BITS-1:0]           v_next;
    logic [PTR_BITS-1:0]         rr_ptr_reg;
    logic [PTR_BITS-1:0]         rr_ptr_next;
    logic [2:0]                  sel_reg;
    logic                        fb_we_reg;
    logic [ADDR_BITS-1:0]        fb_addr_reg;
    logic [ADDR_BITS-1:0]        fb_addr_next;
    logic [3:0]                  fb_data_reg;

    // -----------------------------------------------------------------------
    // Per-core views of the packed return buses and per-core status flags
    // -----------------------------------------------------------------------
    logic [H_BITS-1:0]    ret_h     [NUM_CORES];
    logic [V_BITS-1:0]    ret_v     [NUM_CORES];
    logic [3:0]           ret_color [NUM_CORES];
    logic [NUM_CORES-1:0] free_vec;
    logic [NUM_CORES-1:0] cand_vec;
    logic [NUM_CORES-1:0] disp_vec;
    logic [NUM_CORES-1:0] gnt_vec;

    logic                 disp_found;
    logic                 gnt_found;
    logic [PTR_BITS-1:0]  gnt_idx;
    logic                 last_pix;
    logic                 all_free;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
            assign ret_h[gi]     = core_hcount_in[gi*H_BITS +: H_BITS];
            assign ret_v[gi]     = core_vcount_in[gi*V_BITS +: V_BITS];
            assign ret_color[gi] = core_color_in[gi*4 +: 4];

            assign free_vec[gi]  = (core_state_reg[gi] == CORE_FREE);
            // ARMED cores are deliberately excluded: their ready flag still
            // reflects the previous pixel until the core has latched the new one.
            assign cand_vec[gi]  = (core_state_reg[gi] == CORE_BUSY) && core_ready_in[gi];

            // FREE -> ARMED on dispatch, ARMED -> BUSY unconditionally,
            // BUSY -> FREE once the result has been granted the write port.
            // A core granted this cycle is still BUSY, so it cannot be
            // re-dispatched until the following cycle.
            assign core_state_next[gi] =
                ((core_state_reg[gi] == CORE_FREE)  && disp_vec[gi]) ? CORE_ARMED :
                 (core_state_reg[gi] == CORE_ARMED)                  ? CORE_BUSY  :
                ((core_state_reg[gi] == CORE_BUSY)  && gnt_vec[gi])  ? CORE_FREE  :
                                                                       core_state_reg[gi];
        end
    endgenerate

    assign all_free = &free_vec;
    assign last_pix = (h_reg == H_LAST) && (v_reg == V_LAST);

    // -----------------------------------------------------------------------
    // Dispatch: lowest-index FREE core, only while RUN
    // -----------------------------------------------------------------------
    always_comb begin : dispatch_select
        disp_vec   = '0;
        disp_found = 1'b0;
        if (state_reg == ST_RUN) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (!disp_found && free_vec[i]) begin
                    disp_vec[i] = 1'b1;
                    disp_found  = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Write arbitration: round-robin starting at rr_ptr_reg
    // -----------------------------------------------------------------------
    always_comb begin : grant_arbiter
        int scan_idx;
        gnt_vec   = '0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan_idx = (int'(rr_ptr_reg) + k) % NUM_CORES;
            if (!gnt_found && cand_vec[scan_idx]) begin
                gnt_found         = 1'b1;
                gnt_idx           = PTR_BITS'(scan_idx);
                gnt_vec[scan_idx] = 1'b1;
            end
        end
    end

    // Pointer moves just past the grantee so it has lowest priority next time.
    always_comb begin : ptr_update
        rr_ptr_next = rr_ptr_reg;
        if (gnt_found) begin
            rr_ptr_next = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Linear address of the granted result. The product is deliberately kept
    // at ADDR_BITS: the framebuffer holds exactly one frame.
    assign fb_addr_next = ADDR_BITS'(ret_v[gnt_idx]) * LINE_LEN
                        + ADDR_BITS'(ret_h[gnt_idx]);

    // -----------------------------------------------------------------------
    // Raster counter
    // -----------------------------------------------------------------------
    always_comb begin : raster_next
        h_next = h_reg;
        v_next = v_reg;
        if (state_reg == ST_IDLE) begin
            if (start_in) begin
                h_next = '0;
                v_next = '0;
            end
        end else if (disp_found) begin
            if (h_reg == H_LAST) begin
                h_next = '0;
                // Wrap the line counter too so the counter rests at (0,0)
                // after the final pixel of the frame.
                v_next = (v_reg == V_LAST) ? '0 : v_reg + 1'b1;
            end else begin
                h_next = h_reg + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    always_comb begin : fsm_next
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (start_in)              state_next = ST_RUN;
            ST_RUN:   if (disp_found && last_pix) state_next = ST_DRAIN;
            // A result granted last cycle is on the write port now; wait for
            // it to leave before declaring the frame finished.
            ST_DRAIN: if (all_free && !fb_we_reg) state_next = ST_DONE;
            ST_DONE:                              state_next = ST_IDLE;
            default:                              state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg      <= ST_IDLE;
            core_state_reg <= '0;
            h_reg          <= '0;
            v_reg          <= '0;
            rr_ptr_reg     <= '0;
            sel_reg        <= '0;
            fb_we_reg      <= 1'b0;
            fb_addr_reg    <= '0;
            fb_data_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            core_state_reg <= core_state_next;
            h_reg          <= h_next;
            v_reg          <= v_next;
            rr_ptr_reg     <= rr_ptr_next;
            if ((state_reg == ST_IDLE) && start_in) begin
                sel_reg <= fractal_sel_in;
            end
            fb_we_reg <= gnt_found;
            if (gnt_found) begin
                fb_addr_reg <= fb_addr_next;
                fb_data_reg <= ret_color[gnt_idx];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign core_valid_out  = disp_vec;
    assign pix_hcount_out  = disp_found ? h_reg : '0;
    assign pix_vcount_out  = disp_found ? v_reg : '0;
    assign fractal_sel_out = sel_reg;
    assign fb_we_out       = fb_we_reg;
    assign fb_addr_out     = fb_addr_reg;
    assign fb_data_out     = fb_data_reg;
    assign busy_out        = (state_reg != ST_IDLE);
    assign frame_done_out  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_ray_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ray_scheduler
//
// Scoreboard bench for ray_scheduler on a 4x2 frame with four model cores.
// The stimulus thread pushes expected dispatches and writes into queues;
// a negedge monitor pops and compares them whenever the DUT strobes.
// ---------------------------------------------------------------------------
module tb_ray_scheduler;

    localparam int NC  = 4;
    localparam int W   = 4;
    localparam int H   = 2;
    localparam int HB  = 9;
    localparam int VB  = 9;
    localparam int AB  = 17;
    localparam int LAT = 4;
    localparam int NPIX = W * H;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        sel_in;
    logic [NC-1:0]     core_valid;
    logic [HB-1:0]     pix_h;
    logic [VB-1:0]     pix_v;
    logic [2:0]        sel_out;
    logic [NC-1:0]     core_ready;
    logic [NC*HB-1:0]  core_hc;
    logic [NC*VB-1:0]  core_vc;
    logic [NC*4-1:0]   core_col;
    logic              fb_we;
    logic [AB-1:0]     fb_addr;
    logic [3:0]        fb_data;
    logic              busy;
    logic              frame_done;

    always #5 clk = ~clk;

    ray_scheduler #(
        .NUM_CORES(NC), .DISPLAY_WIDTH(W), .DISPLAY_HEIGHT(H),
        .H_BITS(HB), .V_BITS(VB), .ADDR_BITS(AB)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start), .fractal_sel_in(sel_in),
        .core_valid_out(core_valid), .pix_hcount_out(pix_h), .pix_vcount_out(pix_v),
        .fractal_sel_out(sel_out), .core_ready_in(core_ready),
        .core_hcount_in(core_hc), .core_vcount_in(core_vc), .core_color_in(core_col),
        .fb_we_out(fb_we), .fb_addr_out(fb_addr), .fb_data_out(fb_data),
        .busy_out(busy), .frame_done_out(frame_done)
    );

    // ---------------- model cores ----------------
    // Latch the pixel on dispatch, count LAT cycles, then raise ready. Ready
    // is registered from the old count, so it stays stale-high for one cycle
    // after a dispatch, which the DUT has to ignore.
    logic [HB-1:0] m_h [NC];
    logic [VB-1:0] m_v [NC];
    int            m_cnt [NC];
    logic          hold;

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            if (core_valid[i]) begin
                m_h[i]   <= pix_h;
                m_v[i]   <= pix_v;
                m_cnt[i] <= LAT;
            end else if (m_cnt[i] != 0) begin
                m_cnt[i] <= m_cnt[i] - 1;
            end
            core_ready[i] <= (m_cnt[i] == 0) && !hold;
        end
    end

    always_comb begin
        core_hc  = '0;
        core_vc  = '0;
        core_col = '0;
        for (int i = 0; i < NC; i++) begin
            core_hc[i*HB +: HB] = m_h[i];
            core_vc[i*VB +: VB] = m_v[i];
            core_col[i*4 +: 4]  = m_h[i][3:0] ^ m_v[i][3:0];
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [AB-1:0] addr; logic [3:0] data; } wr_t;
    typedef struct packed { logic [HB-1:0] h; logic [VB-1:0] v; } disp_t;

    wr_t   exp_wr [$];
    disp_t exp_disp [$];

    // Hand-computed 4x2 frame: raster order, addr = v*4+h, shade = h^v.
    int exp_h_tab     [NPIX] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp_v_tab     [NPIX] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int exp_addr_tab  [NPIX] = '{0, 1, 2, 3, 4, 5, 6, 7};
    int exp_shade_tab [NPIX] = '{0, 1, 2, 3, 1, 0, 3, 2};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_disp  = 0;
    int n_writes = 0;
    int n_done  = 0;
    int wr_cyc [64];
    logic [NC-1:0] outstanding;
    int out_addr [NC];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_event(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen, none expected (cycle %0d)", name, cyc);
    endtask

    task automatic push_frame();
        wr_t   w;
        disp_t d;
        for (int i = 0; i < NPIX; i++) begin
            d.h = HB'(exp_h_tab[i]);
            d.v = VB'(exp_v_tab[i]);
            exp_disp.push_back(d);
            w.addr = AB'(exp_addr_tab[i]);
            w.data = 4'(exp_shade_tab[i]);
            exp_wr.push_back(w);
        end
    endtask

    // Monitor: writes are handled before dispatches so a core whose result is
    // on the port this cycle may legally be re-dispatched in the same cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (fb_we) begin
                if (n_writes < 64) wr_cyc[n_writes] = cyc;
                n_writes++;
                if (exp_wr.size() == 0) begin
                    fail_event("unexpected_write");
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    check("wr_addr", 64'(fb_addr), 64'(e.addr));
                    check("wr_data", 64'(fb_data), 64'(e.data));
                    $display("[TB] write addr=%0d data=%0d cycle=%0d", fb_addr, fb_data, cyc);
                end
                for (int i = 0; i < NC; i++)
                    if (outstanding[i] && out_addr[i] == int'(fb_addr)) outstanding[i] = 1'b0;
            end
            if (core_valid != '0) begin
                check("dispatch_onehot", 64'($onehot(core_valid)), 64'd1);
                n_disp++;
                for (int i = 0; i < NC; i++) begin
                    if (core_valid[i]) begin
                        check("no_redispatch", 64'(outstanding[i]), 64'd0);
                        outstanding[i] = 1'b1;
                        out_addr[i]    = int'(pix_v) * W + int'(pix_h);
                        $display("[TB] dispatch core=%0d h=%0d v=%0d cycle=%0d", i, pix_h, pix_v, cyc);
                    end
                end
                if (exp_disp.size() == 0) begin
                    fail_event("unexpected_dispatch");
                end else begin
                    disp_t d;
                    d = exp_disp.pop_front();
                    check("disp_h", 64'(pix_h), 64'(d.h));
                    check("disp_v", 64'(pix_v), 64'(d.v));
                end
            end
            if (frame_done) n_done++;
        end
    end

    task automatic pulse_start(input logic [2:0] sel);
        @(negedge clk);
        sel_in = sel;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Waits for frame_done (bounded), checks busy falls with it.
    task automatic wait_done(input bit drop_start);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) begin
            check("frame_done_timeout", 64'd0, 64'd1);
        end else begin
            check("busy_during_done", 64'(busy), 64'd1);
            if (drop_start) start = 1'b0;
            @(negedge clk);
            check("busy_after_done", 64'(busy), 64'd0);
            check("done_one_cycle", 64'(frame_done), 64'd0);
        end
    endtask

    task automatic wait_disp(input int target);
        int k;
        k = 0;
        while (n_disp < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("dispatch_wait", 64'(n_disp >= target), 64'd1);
    endtask

    task automatic check_idle_zero(input string name);
        check(name, {core_valid, pix_h, pix_v, sel_out, fb_we, fb_addr, fb_data, busy, frame_done}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    int base_done;

    initial begin
        rst = 1'b1; start = 1'b0; sel_in = 3'd0; hold = 1'b0;
        outstanding = '0;
        core_ready  = '0;
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0; m_h[i] = '0; m_v[i] = '0; out_addr[i] = 0;
        end

        // Reset and idle
        repeat (3) @(posedge clk);
        #1 check_idle_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_idle_zero("idle_outputs");
        end

        // Contention: four results released in the same cycle
        hold = 1'b1;
        repeat (3) @(negedge clk);
        push_frame();
        n_writes = 0;
        base_done = n_done;
        pulse_start(3'd3);
        wait_disp(4);
        repeat (8) @(negedge clk);
        check("held_no_write", 64'(n_writes), 64'd0);
        check("held_no_extra_dispatch", 64'(n_disp), 64'd4);
        hold = 1'b0;
        wait_done(1'b0);
        for (int k = 0; k < 3; k++)
            check("contention_consecutive", 64'(wr_cyc[k+1] - wr_cyc[k]), 64'd1);
        check("frame1_writes", 64'(n_writes), 64'(NPIX));
        check("frame1_disp_left", 64'(exp_disp.size()), 64'd0);
        check("frame1_wr_left", 64'(exp_wr.size()), 64'd0);
        repeat (5) @(negedge clk);
        check("frame1_done_pulses", 64'(n_done - base_done), 64'd1);

        // Normal frame, start held through RUN, select changed mid-frame
        push_frame();
        n_writes = 0;
        base_done = n_done;
        @(negedge clk);
        sel_in = 3'd5;
        start  = 1'b1;
        repeat (5) @(negedge clk);
        sel_in = 3'd2;
        check("sel_latched_mid", 64'(sel_out), 64'd5);
        wait_done(1'b1);
        check("sel_latched_end", 64'(sel_out), 64'd5);
        repeat (10) @(negedge clk);
        check("frame2_writes", 64'(n_writes), 64'(NPIX));
        check("frame2_done_pulses", 64'(n_done - base_done), 64'd1);
        check("frame2_wr_left", 64'(exp_wr.size()), 64'd0);

        // Reset mid-frame while a write is on the port
        push_frame();
        n_disp = 0;
        n_writes = 0;
        pulse_start(3'd1);
        wait_disp(3);
        for (int k = 0; k < 100 && !fb_we; k++) @(negedge clk);
        check("midframe_write_seen", 64'(fb_we), 64'd1);
        #2 rst = 1'b1;
        #1 check("reset_we_cleared", 64'(fb_we), 64'd0);
        check("reset_busy_cleared", 64'(busy), 64'd0);
        check("reset_sel_cleared", 64'(sel_out), 64'd0);
        exp_wr.delete();
        exp_disp.delete();
        outstanding = '0;
        base_done = n_done;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check("post_reset_idle", {fb_we, frame_done, busy}, 64'd0);
        end
        check("no_done_after_abort", 64'(n_done - base_done), 64'd0);

        // Fresh frame after the abort
        push_frame();
        n_writes = 0;
        base_done = n_done;
        pulse_start(3'd6);
        wait_done(1'b0);
        check("frame3_writes", 64'(n_writes), 64'(NPIX));
        check("frame3_sel", 64'(sel_out), 64'd6);
        repeat (5) @(negedge clk);
        check("frame3_done_pulses", 64'(n_done - base_done), 64'd1);
        check("frame3_disp_left", 64'(exp_disp.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
